// File: rtl/riscv_pkg.sv
// Shared RV32 execute-stage definitions: ALU and M-extension op codes, muldiv states.
// Used by ex_stage and ex_muldiv (the latter only exists when EX_MULDIV_EN is defined).
package riscv_pkg;

  localparam int DEF_BIT_W = 32;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring-subtract steps on magnitudes,
// sign fix applied in DONE. Built only when EX_MULDIV_EN is defined.
//
// state   | meaning
// IDLE    | waiting for an M op; latches magnitudes, signs, counter = 31
// BUSY    | one step per cycle until the counter reaches 0
// DONE    | result valid; held while stall is high
`ifdef EX_MULDIV_EN
module ex_muldiv
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic        stall,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] result
);

  md_state_e   state, state_nxt;
  logic [4:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] hi, lo, mcand;
  logic        neg_q, neg_r;

  logic        is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, special;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] prod_fix;

  always_comb begin
    is_div   = op[2];
    a_sgn    = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    b_sgn    = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    a_neg    = a_sgn & a[31];
    b_neg    = b_sgn & b[31];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = is_div && (b == 32'd0);
    div_ovf  = ((op == MD_DIV) || (op == MD_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    special  = div_zero | div_ovf;
  end

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : 33'd0);
    div_shift = {hi, lo[31]};
    div_diff  = div_shift - {1'b0, mcand};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = MD_IDLE;
    end else begin
      case (state)
        MD_IDLE: if (start) state_nxt = special ? MD_DONE : MD_BUSY;
        MD_BUSY: if (cnt == 5'd0) state_nxt = MD_DONE;
        MD_DONE: if (!stall) state_nxt = MD_IDLE;
        default: state_nxt = MD_IDLE;
      endcase
    end
  end

  // Specials preload hi/lo with the final remainder/quotient so DONE needs no extra mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      op_q  <= '0;
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start && !flush) begin
            op_q  <= op;
            cnt   <= 5'd31;
            mcand <= is_div ? b_mag : a_mag;
            if (div_zero) begin
              hi    <= a;
              lo    <= 32'hFFFF_FFFF;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else if (div_ovf) begin
              hi    <= 32'd0;
              lo    <= 32'h8000_0000;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              hi    <= 32'd0;
              lo    <= is_div ? a_mag : b_mag;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
            end
          end
        end
        MD_BUSY: begin
          cnt <= cnt - 5'd1;
          if (op_q[2]) begin
            hi <= div_diff[32] ? div_shift[31:0] : div_diff[31:0];
            lo <= {lo[30:0], ~div_diff[32]};
          end else begin
            hi <= mul_sum[32:1];
            lo <= {mul_sum[0], lo[31:1]};
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    prod_fix = neg_q ? -{hi, lo} : {hi, lo};
    case (op_q)
      MD_MUL:                      result = prod_fix[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[63:32];
      MD_DIV, MD_DIVU:             result = neg_q ? -lo : lo;
      default:                     result = neg_r ? -hi : hi;
    endcase
    done = (state == MD_DONE);
  end

endmodule
`endif

// File: rtl/ex_stage.sv
// RV32 execute stage: single-cycle ALU, optional iterative muldiv, and the EX/MEM register.
// Macro EX_MULDIV_EN builds the muldiv unit; without it M ops return 0 in one cycle.
module ex_stage
  import riscv_pkg::*;
#(
  parameter int BIT_W = DEF_BIT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIT_W-1:0] rs1_data_in,
  input  logic [BIT_W-1:0] rs2_data_in,
  input  logic [BIT_W-1:0] imm_in,
  input  logic             alusrc_in,
  input  logic [3:0]       alu_op_in,
  input  logic             md_valid_in,
  input  logic [2:0]       md_op_in,
  input  logic             memrd_in,
  input  logic             memwr_in,
  input  logic             mem2reg_in,
  input  logic             regwr_in,
  input  logic             jump_in,
  input  logic [4:0]       rd_in,
  input  logic [BIT_W-1:0] PC_step_in,
  input  logic             stall_in,
  input  logic             flush_in,
  output logic             ex_busy,
  output logic [BIT_W-1:0] alu_result_out,
  output logic [BIT_W-1:0] mem_wdata_out,
  output logic [BIT_W-1:0] PC_step_out,
  output logic [4:0]       rd_out,
  output logic             memrd_out,
  output logic             memwr_out,
  output logic             mem2reg_out,
  output logic             regwr_out,
  output logic             jump_out
);

  logic [BIT_W-1:0] op_b, alu_res, md_result, ex_result;

  always_comb begin
    op_b = alusrc_in ? imm_in : rs2_data_in;
    case (alu_op_in)
      ALU_ADD:   alu_res = rs1_data_in + op_b;
      ALU_SUB:   alu_res = rs1_data_in - op_b;
      ALU_AND:   alu_res = rs1_data_in & op_b;
      ALU_OR:    alu_res = rs1_data_in | op_b;
      ALU_XOR:   alu_res = rs1_data_in ^ op_b;
      ALU_SLL:   alu_res = rs1_data_in << op_b[4:0];
      ALU_SRL:   alu_res = rs1_data_in >> op_b[4:0];
      ALU_SRA:   alu_res = $unsigned($signed(rs1_data_in) >>> op_b[4:0]);
      ALU_SLT:   alu_res = {{(BIT_W-1){1'b0}}, $signed(rs1_data_in) < $signed(op_b)};
      ALU_SLTU:  alu_res = {{(BIT_W-1){1'b0}}, rs1_data_in < op_b};
      ALU_PASSB: alu_res = op_b;
      default:   alu_res = '0;
    endcase
  end

`ifdef EX_MULDIV_EN
  logic md_done;

  ex_muldiv u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_valid_in),
    .flush  (flush_in),
    .stall  (stall_in),
    .op     (md_op_in),
    .a      (rs1_data_in),
    .b      (rs2_data_in),
    .done   (md_done),
    .result (md_result)
  );

  assign ex_busy = md_valid_in & ~md_done;
`else
  logic unused_md_op;

  assign md_result    = '0;
  assign ex_busy      = 1'b0;
  assign unused_md_op = ^md_op_in;
`endif

  assign ex_result = md_valid_in ? md_result : alu_res;

  // Bubbles still load rd/PC_step and the datapath; only the enables are cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_out <= '0;
      mem_wdata_out  <= '0;
      PC_step_out    <= '0;
      rd_out         <= '0;
      memrd_out      <= 1'b0;
      memwr_out      <= 1'b0;
      mem2reg_out    <= 1'b0;
      regwr_out      <= 1'b0;
      jump_out       <= 1'b0;
    end else if (!stall_in) begin
      alu_result_out <= ex_result;
      mem_wdata_out  <= rs2_data_in;
      PC_step_out    <= PC_step_in;
      rd_out         <= rd_in;
      if (flush_in || ex_busy) begin
        memrd_out   <= 1'b0;
        memwr_out   <= 1'b0;
        mem2reg_out <= 1'b0;
        regwr_out   <= 1'b0;
        jump_out    <= 1'b0;
      end else begin
        memrd_out   <= memrd_in;
        memwr_out   <= memwr_in;
        mem2reg_out <= mem2reg_in;
        regwr_out   <= regwr_in;
        jump_out    <= jump_in;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a driver pushes per-cycle expectations from a behavioural
// model, a negedge monitor pops and compares. Follows EX_MULDIV_EN for the M-op model.
module tb_ex_stage;
  import riscv_pkg::*;

`ifdef EX_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rs1_data_in, rs2_data_in, imm_in, PC_step_in;
  logic        alusrc_in, md_valid_in, memrd_in, memwr_in, mem2reg_in, regwr_in, jump_in;
  logic [3:0]  alu_op_in;
  logic [2:0]  md_op_in;
  logic [4:0]  rd_in;
  logic        stall_in, flush_in;
  logic        ex_busy;
  logic [31:0] alu_result_out, mem_wdata_out, PC_step_out;
  logic [4:0]  rd_out;
  logic        memrd_out, memwr_out, mem2reg_out, regwr_out, jump_out;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in), .imm_in(imm_in),
    .alusrc_in(alusrc_in), .alu_op_in(alu_op_in),
    .md_valid_in(md_valid_in), .md_op_in(md_op_in),
    .memrd_in(memrd_in), .memwr_in(memwr_in), .mem2reg_in(mem2reg_in),
    .regwr_in(regwr_in), .jump_in(jump_in), .rd_in(rd_in), .PC_step_in(PC_step_in),
    .stall_in(stall_in), .flush_in(flush_in), .ex_busy(ex_busy),
    .alu_result_out(alu_result_out), .mem_wdata_out(mem_wdata_out), .PC_step_out(PC_step_out),
    .rd_out(rd_out), .memrd_out(memrd_out), .memwr_out(memwr_out),
    .mem2reg_out(mem2reg_out), .regwr_out(regwr_out), .jump_out(jump_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  alu_op;
    bit          md;
    logic [2:0]  md_op;
    logic [31:0] rs1, rs2, imm, pc;
    bit          alusrc, memrd, memwr, m2r, regwr, jump;
    logic [4:0]  rd;
  } instr_t;

  typedef struct {
    bit          busy;
    bit          known;
    logic [31:0] res, wdata, pc;
    logic [4:0]  rd, ctrl;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  logic [31:0] m_res, m_wdata, m_pc;
  logic [4:0]  m_rd, m_ctrl;
  bit          m_known;
  bit          md_act;
  int          md_k, md_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_XOR:   return a ^ b;
      ALU_SLL:   return a << b[4:0];
      ALU_SRL:   return a >> b[4:0];
      ALU_SRA:   return sa >>> b[4:0];
      ALU_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      ALU_PASSB: return b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic bit md_special(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (op >= MD_DIV && b == 32'd0) return 1'b1;
    if ((op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [31:0] sa, sb;
    longint p;
    logic [63:0] pv;
    sa = a;
    sb = b;
    case (op)
      MD_MUL:    begin p = longint'(sa) * longint'(sb); pv = p; return pv[31:0]; end
      MD_MULH:   begin p = longint'(sa) * longint'(sb); pv = p; return pv[63:32]; end
      MD_MULHSU: begin p = longint'(sa) * longint'({32'd0, b}); pv = p; return pv[63:32]; end
      MD_MULHU:  begin pv = {32'd0, a} * {32'd0, b}; return pv[63:32]; end
      MD_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      MD_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      MD_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default:   return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] ref_result(input instr_t in);
    if (in.md) return MD_EN ? ref_md(in.md_op, in.rs1, in.rs2) : 32'd0;
    return ref_alu(in.alu_op, in.rs1, in.alusrc ? in.imm : in.rs2);
  endfunction

  function automatic instr_t mk_alu(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] imm, input bit src);
    instr_t in;
    in = '{alu_op: op, md: 1'b0, md_op: 3'd0, rs1: a, rs2: b, imm: imm, pc: $urandom,
           alusrc: src, memrd: 1'b0, memwr: 1'b0, m2r: 1'b0, regwr: 1'b1, jump: 1'b0,
           rd: 5'($urandom_range(1, 31))};
    return in;
  endfunction

  function automatic instr_t mk_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    instr_t in;
    in = mk_alu(ALU_ADD, a, b, 32'd0, 1'b0);
    in.md = 1'b1;
    in.md_op = op;
    return in;
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t in;
    in = '{alu_op: 4'($urandom_range(0, 15)), md: ($urandom_range(0, 2) == 0),
           md_op: 3'($urandom_range(0, 7)), rs1: pick32(), rs2: pick32(), imm: pick32(),
           pc: $urandom, alusrc: 1'($urandom), memrd: 1'($urandom), memwr: 1'($urandom),
           m2r: 1'($urandom), regwr: 1'($urandom), jump: 1'($urandom), rd: 5'($urandom)};
    return in;
  endfunction

  task automatic drive(input instr_t in);
    rs1_data_in = in.rs1;   rs2_data_in = in.rs2; imm_in = in.imm;
    alusrc_in   = in.alusrc; alu_op_in  = in.alu_op;
    md_valid_in = in.md;    md_op_in    = in.md_op;
    memrd_in    = in.memrd; memwr_in    = in.memwr; mem2reg_in = in.m2r;
    regwr_in    = in.regwr; jump_in     = in.jump;
    rd_in       = in.rd;    PC_step_in  = in.pc;
  endtask

  task automatic model_reset();
    m_res = '0; m_wdata = '0; m_pc = '0; m_rd = '0; m_ctrl = '0;
    m_known = 1'b1; md_act = 1'b0; md_k = 0; md_lat = 0;
  endtask

  // Holds one instruction in EX until it is captured or squashed; one expectation per cycle.
  task automatic run_instr(input instr_t in, input int stall_at, input int stall_len,
                           input int flush_at, input bit rnd_stall);
    int c;
    bit stall, flush, busy, fin;
    exp_t e;
    logic [31:0] r;
    r = ref_result(in);
    c = 0;
    fin = 1'b0;
    drive(in);
    while (!fin) begin
      stall = rnd_stall ? ($urandom_range(0, 3) == 0) : (c >= stall_at && c < stall_at + stall_len);
      flush = (c == flush_at) && !stall;
      stall_in = stall;
      flush_in = flush;
      if (MD_EN && in.md && !md_act) begin
        md_act = 1'b1;
        md_k   = 0;
        md_lat = md_special(in.md_op, in.rs1, in.rs2) ? 1 : 33;
      end
      busy = MD_EN && in.md && (md_k < md_lat);
      e = '{busy: busy, known: m_known, res: m_res, wdata: m_wdata, pc: m_pc, rd: m_rd, ctrl: m_ctrl};
      sb_q.push_back(e);
      if (!stall) begin
        m_rd = in.rd;
        m_pc = in.pc;
        if (flush || busy) begin
          m_ctrl  = '0;
          m_known = 1'b0;
        end else begin
          m_ctrl  = {in.memrd, in.memwr, in.m2r, in.regwr, in.jump};
          m_res   = r;
          m_wdata = in.rs2;
          m_known = 1'b1;
        end
      end
      if (flush) md_act = 1'b0;
      else if (md_act) begin
        if (md_k >= md_lat && !stall) md_act = 1'b0;
        else md_k++;
      end
      fin = !stall && (flush || !busy);
      @(posedge clk);
      #1;
      c++;
      if (!fin && c >= 400) begin
        total++;
        bad++;
        $display("FAIL instr_timeout: still in EX after %0d cycles, required completion", c);
        fin = 1'b1;
      end
    end
    stall_in = 1'b0;
    flush_in = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got no expectation, required one per cycle");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("ex_busy", 32'(ex_busy), 32'(e.busy));
        chk("ctrl", 32'({memrd_out, memwr_out, mem2reg_out, regwr_out, jump_out}), 32'(e.ctrl));
        chk("rd", 32'(rd_out), 32'(e.rd));
        chk("pc_step", PC_step_out, e.pc);
        if (e.known) begin
          chk("alu_result", alu_result_out, e.res);
          chk("mem_wdata", mem_wdata_out, e.wdata);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t zero_in;
    zero_in = '{alu_op: 4'd0, md: 1'b0, md_op: 3'd0, rs1: 32'd0, rs2: 32'd0, imm: 32'd0,
                pc: 32'd0, alusrc: 1'b0, memrd: 1'b0, memwr: 1'b0, m2r: 1'b0, regwr: 1'b0,
                jump: 1'b0, rd: 5'd0};
    rst_n = 1'b1;
    drive(zero_in);
    stall_in = 1'b0;
    flush_in = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_ctrl", 32'({memrd_out, memwr_out, mem2reg_out, regwr_out, jump_out, ex_busy}), 32'd0);
    chk("reset_data", alu_result_out | mem_wdata_out | PC_step_out | 32'(rd_out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    mon_en = 1'b1;

    run_instr(mk_alu(ALU_ADD, 32'd5, 32'd0, 32'hFFFF_FFF8, 1'b1), -1, 0, -1, 1'b0);
    run_instr(mk_alu(ALU_SRA, 32'h8000_0000, 32'd4, 32'd0, 1'b0), -1, 0, -1, 1'b0);
    run_instr(mk_alu(ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0), -1, 0, -1, 1'b0);
    run_instr(mk_md(MD_MUL, 32'hFFFF_FFFF, 32'd3), -1, 0, -1, 1'b0);
    run_instr(mk_md(MD_MULHU, 32'hFFFF_FFFF, 32'd3), -1, 0, -1, 1'b0);
    run_instr(mk_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF), -1, 0, -1, 1'b0);
    run_instr(mk_md(MD_REM, 32'hFFFF_FFF9, 32'd2), -1, 0, -1, 1'b0);
    run_instr(mk_md(MD_DIVU, 32'h1234_5678, 32'd0), -1, 0, -1, 1'b0);
    run_instr(mk_md(MD_MULH, 32'h8000_0001, 32'h7FFF_FFFF), 33, 5, -1, 1'b0);
    run_instr(mk_md(MD_DIV, 32'hFFFF_FF00, 32'd7), -1, 0, 10, 1'b0);
    run_instr(mk_alu(ALU_XOR, 32'hA5A5_0000, 32'h0000_5A5A, 32'd0, 1'b0), -1, 0, -1, 1'b0);
    run_instr(mk_md(MD_MULHSU, 32'hFFFF_FFFE, 32'hFFFF_FFFF), -1, 0, -1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      run_instr(rand_instr(), -1, 0, ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 36)) : -1, 1'b1);
    end
    mon_en = 1'b0;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    // Async reset in the middle of a long op, then a full-latency op proves the FSM restarted.
    drive(mk_md(MD_MUL, 32'd1234, 32'd77));
    repeat (12) @(posedge clk);
    #3;
    rst_n = 1'b0;
    drive(zero_in);
    #1;
    chk("rst_busy", 32'(ex_busy), 32'd0);
    chk("rst_ctrl", 32'({memrd_out, memwr_out, mem2reg_out, regwr_out, jump_out}), 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    chk("rst_pc", PC_step_out, 32'd0);
    chk("rst_res", alu_result_out, 32'd0);
    chk("rst_wdata", mem_wdata_out, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    mon_en = 1'b1;
    run_instr(mk_md(MD_REMU, 32'd1000, 32'd7), -1, 0, -1, 1'b0);
    run_instr(mk_alu(ALU_SUB, 32'd3, 32'd5, 32'd0, 1'b0), -1, 0, -1, 1'b0);
    mon_en = 1'b0;
    chk("sb_drained_end", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
